// File: rtl/ecc_arb_pkg.sv
// Shared constants and the FSM state type for the ECC job arbiter.
package ecc_arb_pkg;

  localparam int ECC_W     = 163;
  localparam int ECC_OUT_W = 176;
  localparam int MAX_REQ   = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ecc_job_arbiter_if.sv
// Bundle of requester, response and processor-side signals of the ECC job arbiter.
interface ecc_job_arbiter_if
  import ecc_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) ();

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*ECC_W-1:0] req_k;
  logic [N_REQ*ECC_W-1:0] req_g;
  logic [N_REQ-1:0]       req_ready;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [ECC_W-1:0]       rsp_xa;
  logic [ECC_W-1:0]       rsp_za;
  logic                   rsp_err;

  logic                   ecc_start;
  logic [ECC_W-1:0]       ecc_k;
  logic [ECC_W-1:0]       ecc_g;
  logic [ECC_OUT_W-1:0]   ecc_xa;
  logic [ECC_OUT_W-1:0]   ecc_za;
  logic                   ecc_done;
  logic                   ecc_abort;

  modport master (
    input  req_valid, req_k, req_g,
    output req_ready,
    output rsp_valid, rsp_id, rsp_xa, rsp_za, rsp_err,
    input  rsp_ready,
    output ecc_start, ecc_k, ecc_g, ecc_abort,
    input  ecc_xa, ecc_za, ecc_done
  );

  modport slave (
    output req_valid, req_k, req_g,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_xa, rsp_za, rsp_err,
    output rsp_ready,
    input  ecc_start, ecc_k, ecc_g, ecc_abort,
    output ecc_xa, ecc_za, ecc_done
  );

endinterface

// File: rtl/ecc_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module ecc_rr_picker
  import ecc_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             grant_vld,
  output logic [ID_W-1:0]  grant_id
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  // Rotate so that bit 0 is the requester at rr_ptr; the lowest set bit then wins.
  assign dbl = {req_valid, req_valid} >> rr_ptr;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!grant_vld && rot[j]) begin
        idx = int'(rr_ptr) + j;
        if (idx >= N_REQ) idx = idx - N_REQ;
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ecc_job_arbiter.sv
// Shares one ecc_processor among N_REQ requesters; one job in flight at a time.
// Optional watchdog enabled by defining ECC_ARB_TIMEOUT_EN.
module ecc_job_arbiter
  import ecc_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TMO_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  ecc_job_arbiter_if.master  bus
);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [ECC_W-1:0] k_q, g_q, xa_q, za_q;
  logic             err_q;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic             timeout_hit;

  logic [N_REQ-1:0] req_ready_c;
  logic             start_c, rsp_valid_c, abort_c;

  logic             unused_hi;
  assign unused_hi = ^{bus.ecc_xa[ECC_OUT_W-1:ECC_W], bus.ecc_za[ECC_OUT_W-1:ECC_W]};

  ecc_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

`ifdef ECC_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign timeout_hit = (state == BUSY) && (wd_cnt == 32'(TMO_CYC - 1));

  // Watchdog: cleared in START, counts each BUSY cycle; a done in the hit cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == START) wd_cnt <= '0;
      else if (state == BUSY) wd_cnt <= wd_cnt + 32'd1;
      if (state == BUSY) begin
        if (bus.ecc_done) err_q <= 1'b0;
        else if (timeout_hit) err_q <= 1'b1;
      end
    end
  end
`else
  localparam int unused_tmo = TMO_CYC;
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == RESP && bus.rsp_ready) rr_ptr <= ID_W'(wrap_inc(int'(cur_id), N_REQ));
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = '0;
    start_c     = 1'b0;
    rsp_valid_c = 1'b0;
    abort_c     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready_c = N_REQ'(1) << grant_id;
          state_nxt   = START;
        end
      end
      START: begin
        start_c   = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.ecc_done) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          abort_c   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched on grant and held until the next grant; results on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id <= '0;
      k_q    <= '0;
      g_q    <= '0;
      xa_q   <= '0;
      za_q   <= '0;
    end else begin
      if (state == IDLE && grant_vld) begin
        cur_id <= grant_id;
        k_q    <= bus.req_k[int'(grant_id)*ECC_W +: ECC_W];
        g_q    <= bus.req_g[int'(grant_id)*ECC_W +: ECC_W];
      end
      if (state == BUSY) begin
        if (bus.ecc_done) begin
          xa_q <= bus.ecc_xa[ECC_W-1:0];
          za_q <= bus.ecc_za[ECC_W-1:0];
        end else if (timeout_hit) begin
          xa_q <= '0;
          za_q <= '0;
        end
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.ecc_start = start_c;
  assign bus.ecc_abort = abort_c;
  assign bus.ecc_k     = k_q;
  assign bus.ecc_g     = g_q;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_id    = cur_id;
  assign bus.rsp_xa    = xa_q;
  assign bus.rsp_za    = za_q;
  assign bus.rsp_err   = err_q;

endmodule
